// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

    // Arbiter control state: IDLE = no holder, BUSY = a requester owns the write port.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int N_REQ_DEF      = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int MAX_BURST_DEF  = 4;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request searching upward from last+1, wrapping.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic                     any,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int GID_W = $clog2(N_REQ);

    // Scan N_REQ positions starting just after 'last'; the first hit wins.
    always_comb begin
        int              j;
        logic [GID_W-1:0] jj;
        any = 1'b0;
        idx = '0;
        j   = 0;
        jj  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            j  = (int'(last) + k) % N_REQ;
            jj = GID_W'(j);
            if (!any && req[jj]) begin
                any = 1'b1;
                idx = jj;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among N_REQ producers.
// A winner keeps the port for up to MAX_BURST accepted words; the FIFO full flag
// only stalls the holder, it never takes the grant away.
//
// Handshake: a word on slice i is transferred on a rising wclk edge where
// req_valid[i] && req_ready[i]; the same cycle drives w_en=1 with that word on
// data_in. A producer must hold its word stable while valid=1 and ready=0.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int Data_Width = DATA_WIDTH_DEF,
    parameter int MAX_BURST  = MAX_BURST_DEF
) (
    input  logic                        wclk,
    input  logic                        w_rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*Data_Width-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        full,
    output logic                        w_en,
    output logic [Data_Width-1:0]       data_in,
    output logic                        grant_valid,
    output logic [$clog2(N_REQ)-1:0]    grant_id
);

    localparam int GID_W  = $clog2(N_REQ);
    localparam int BEAT_W = $clog2(MAX_BURST) + 1;

    arb_state_t        state_q,    state_d;
    logic [GID_W-1:0]  gnt_q,      gnt_d;
    logic [GID_W-1:0]  last_gnt_q, last_gnt_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic              busy;
    logic              holder_valid;
    logic              accept;
    logic              last_beat;
    logic              release_gnt;
    logic              idle_any,   rel_any;
    logic [GID_W-1:0]  idle_idx,   rel_idx;

    // Pick used when starting from IDLE, priority from the stored RR pointer.
    rr_pick #(.N_REQ(N_REQ)) u_idle_pick (
        .req  (req_valid),
        .last (last_gnt_q),
        .any  (idle_any),
        .idx  (idle_idx)
    );

    // Pick used on release, priority from the current holder + 1.
    rr_pick #(.N_REQ(N_REQ)) u_rel_pick (
        .req  (req_valid),
        .last (gnt_q),
        .any  (rel_any),
        .idx  (rel_idx)
    );

    // Datapath and handshake outputs derived from the registered grant.
    always_comb begin
        busy         = (state_q == BUSY);
        holder_valid = req_valid[gnt_q];
        accept       = busy && holder_valid && !full;
        last_beat    = (beat_cnt_q == BEAT_W'(MAX_BURST - 1));
        release_gnt  = busy && ((accept && last_beat) || !holder_valid);

        w_en         = accept;
        req_ready    = '0;
        if (accept) begin
            req_ready[gnt_q] = 1'b1;
        end
        data_in      = busy ? req_data[int'(gnt_q)*Data_Width +: Data_Width] : '0;
        grant_valid  = busy;
        grant_id     = gnt_q;
    end

    // Next-state: arbitrate from IDLE, count beats, release and re-arbitrate with no bubble.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (idle_any) begin
                    state_d    = BUSY;
                    gnt_d      = idle_idx;
                    last_gnt_d = idle_idx;
                    beat_cnt_d = '0;
                end
            end
            BUSY: begin
                if (release_gnt) begin
                    beat_cnt_d = '0;
                    if (rel_any) begin
                        gnt_d      = rel_idx;
                        last_gnt_d = rel_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter registers; reset points the RR pointer at N_REQ-1 so requester 0 leads.
    always_ff @(posedge wclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            last_gnt_q <= GID_W'(N_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N_REQ=4, MAX_BURST=4, Data_Width=8).
module tb_fifo_wr_arbiter;

    // ---------------- clock / reset ----------------
    logic        wclk;
    logic        w_rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        full;
    logic        w_en;
    logic [7:0]  data_in;
    logic        grant_valid;
    logic [1:0]  grant_id;

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(
        .N_REQ      (4),
        .Data_Width (8),
        .MAX_BURST  (4)
    ) dut (
        .wclk        (wclk),
        .w_rst_n     (w_rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .full        (full),
        .w_en        (w_en),
        .data_in     (data_in),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int         checks   = 0;
    int         failures = 0;

    // Producer model: each requester emits base + count, count advances on ready.
    logic [7:0] base[4];
    logic [7:0] cnt[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_data();
        for (int i = 0; i < 4; i++) begin
            req_data[i*8 +: 8] = base[i] + cnt[i];
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".w_en"},        32'(w_en),        32'(0));
        chk({tag, ".req_ready"},   32'(req_ready),   32'(0));
        chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(0));
        chk({tag, ".grant_id"},    32'(grant_id),    32'(0));
        chk({tag, ".data_in"},     32'(data_in),     32'(0));
    endtask

    // Called at a negedge: hold reset with random inputs, then release with inputs quiet.
    task automatic do_reset(input string tag, input bit clear_cnt);
        w_rst_n = 1'b0;
        for (int r = 0; r < 3; r++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_data  = $urandom;
            full      = 1'($urandom_range(0, 1));
            #1;
            chk_reset_outputs(tag);
            @(negedge wclk);
        end
        req_valid = '0;
        full      = 1'b0;
        if (clear_cnt) begin
            for (int i = 0; i < 4; i++) cnt[i] = '0;
        end
        w_rst_n = 1'b1;
    endtask

    // One clock: sample outputs after the negedge, score writes, advance producers on ready.
    task automatic tick(input string tag, input logic exp_gv, input logic [1:0] exp_gid,
                        input logic exp_wen);
        logic [3:0] rdy;
        logic [7:0] exp_word;
        drive_data();
        #1;
        chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(exp_gv));
        if (exp_gv) chk({tag, ".grant_id"}, 32'(grant_id), 32'(exp_gid));
        chk({tag, ".w_en"}, 32'(w_en), 32'(exp_wen));
        if (w_en) begin
            chk({tag, ".req_ready"}, 32'(req_ready), 32'(4'b0001 << grant_id));
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL %s.unexpected_write observed=%0h expected=none", tag, data_in);
            end
            if (exp_q.size() != 0) begin
                exp_word = exp_q.pop_front();
                chk({tag, ".data_in"}, 32'(data_in), 32'(exp_word));
            end
        end else begin
            chk({tag, ".req_ready"}, 32'(req_ready), 32'(0));
        end
        rdy = req_ready;
        @(posedge wclk);
        for (int i = 0; i < 4; i++) begin
            if (rdy[i]) cnt[i] = cnt[i] + 8'd1;
        end
        @(negedge wclk);
    endtask

    task automatic chk_drained(input string tag);
        chk({tag, ".exp_q_left"}, 32'(exp_q.size()), 32'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        w_rst_n   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        full      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            base[i] = 8'(i * 16);
            cnt[i]  = '0;
        end
        @(negedge wclk);

        // 1: reset with random inputs
        do_reset("t1_reset", 1'b1);

        // 2: only requester 2, burst of 4 then same-cycle re-grant
        do_reset("t2_reset", 1'b1);
        req_valid = 4'b0100;
        for (int k = 0; k < 5; k++) exp_q.push_back(8'(8'h20 + k));
        tick("t2_arb", 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 5; k++) tick("t2_beat", 1'b1, 2'd2, 1'b1);
        req_valid = 4'b0000;
        tick("t2_drop", 1'b1, 2'd2, 1'b0);
        tick("t2_idle", 1'b0, 2'd0, 1'b0);
        chk_drained("t2");

        // 3: all requesters valid, grants 0,1,2,3,0 with 4 beats each
        do_reset("t3_reset", 1'b1);
        req_valid = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            exp_q.push_back(8'(((k / 4) % 4) * 16 + (k / 16) * 4 + (k % 4)));
        end
        tick("t3_arb", 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 20; k++) tick("t3_beat", 1'b1, 2'((k / 4) % 4), 1'b1);
        chk_drained("t3");

        // 4: full stalls requester 0 after two beats; burst completes, then requester 1
        do_reset("t4_reset", 1'b1);
        req_valid = 4'b0011;
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        exp_q.push_back(8'h10);
        tick("t4_arb", 1'b0, 2'd0, 1'b0);
        tick("t4_beat", 1'b1, 2'd0, 1'b1);
        tick("t4_beat", 1'b1, 2'd0, 1'b1);
        full = 1'b1;
        for (int k = 0; k < 3; k++) tick("t4_full", 1'b1, 2'd0, 1'b0);
        full = 1'b0;
        tick("t4_resume", 1'b1, 2'd0, 1'b1);
        tick("t4_resume", 1'b1, 2'd0, 1'b1);
        tick("t4_next", 1'b1, 2'd1, 1'b1);
        chk_drained("t4");

        // 5: requester 1 drops valid after two beats, requester 3 takes over
        do_reset("t5_reset", 1'b1);
        req_valid = 4'b1010;
        exp_q.push_back(8'h10); exp_q.push_back(8'h11);
        for (int k = 0; k < 5; k++) exp_q.push_back(8'(8'h30 + k));
        tick("t5_arb", 1'b0, 2'd0, 1'b0);
        tick("t5_r1", 1'b1, 2'd1, 1'b1);
        tick("t5_r1", 1'b1, 2'd1, 1'b1);
        req_valid = 4'b1000;
        tick("t5_drop", 1'b1, 2'd1, 1'b0);
        for (int k = 0; k < 5; k++) tick("t5_r3", 1'b1, 2'd3, 1'b1);
        chk_drained("t5");

        // 6: reset mid-burst while requester 2 holds the grant
        do_reset("t6_reset", 1'b1);
        req_valid = 4'b1111;
        for (int k = 0; k < 9; k++) exp_q.push_back(8'((k / 4) * 16 + (k % 4)));
        tick("t6_arb", 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 9; k++) tick("t6_beat", 1'b1, 2'(k / 4), 1'b1);
        drive_data();
        #1;
        chk("t6_pre.grant_valid", 32'(grant_valid), 32'(1));
        chk("t6_pre.grant_id",    32'(grant_id),    32'(2));
        #1;
        w_rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6_mid");
        chk_drained("t6_mid");
        @(negedge wclk);
        do_reset("t6_hold", 1'b0);
        req_valid = 4'b1111;
        exp_q.push_back(8'h04);
        tick("t6_arb2", 1'b0, 2'd0, 1'b0);
        tick("t6_first", 1'b1, 2'd0, 1'b1);
        chk_drained("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
